// File: rtl/cpu_debug_pkg.sv
// -----------------------------------------------------------------------------
// cpu_debug_pkg
// Shared definitions for the CPU debug scan engine:
//   - default scan-register / instruction widths
//   - bit positions inside the ir_out status word
//   - scan FSM state encoding and the decoded scan-step action
//   - decode_step(): resolves simultaneous strobes (uir > cdr > sdr > udr)
// -----------------------------------------------------------------------------
package cpu_debug_pkg;

    localparam int DEF_DATA_W = 38;
    localparam int DEF_IR_W   = 2;

    // Positions inside ir_out; every other bit reads as 0.
    localparam int IR_OUT_PEND_BIT = 0;
    localparam int IR_OUT_OVR_BIT  = 1;

    // Scan progress. The PENDING condition is orthogonal to these states
    // and is carried by the upd_valid register in the top level.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURED = 2'd1,
        ST_SHIFTING = 2'd2
    } scan_state_e;

    // At most one action takes effect per step.
    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_UIR  = 3'd1,
        ACT_CDR  = 3'd2,
        ACT_SDR  = 3'd3,
        ACT_UDR  = 3'd4
    } scan_act_e;

    function automatic scan_act_e decode_step(
        input logic tck_en,
        input logic uir,
        input logic cdr,
        input logic sdr,
        input logic udr
    );
        if (!tck_en) return ACT_NONE;
        if (uir)     return ACT_UIR;
        if (cdr)     return ACT_CDR;
        if (sdr)     return ACT_SDR;
        if (udr)     return ACT_UDR;
        return ACT_NONE;
    endfunction

endpackage

// File: rtl/cpu_debug_scan_shreg.sv
// -----------------------------------------------------------------------------
// cpu_debug_scan_shreg
// Capture/shift data register with a saturating shift counter.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   cap_en_i        : load cap_word_i and clear the shift count
//   shift_en_i      : shift right, tdi_i enters at the MSB, count saturates
//   cap_word_i      : word captured on cap_en_i
//   tdi_i           : serial data in
//   sr_o            : current register contents (sr_o[0] drives tdo)
//   full_o          : shift count has reached DATA_W
// cap_en_i and shift_en_i are mutually exclusive by construction upstream.
// -----------------------------------------------------------------------------
module cpu_debug_scan_shreg
    import cpu_debug_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_en_i,
    input  logic              shift_en_i,
    input  logic [DATA_W-1:0] cap_word_i,
    input  logic              tdi_i,
    output logic [DATA_W-1:0] sr_o,
    output logic              full_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    logic [DATA_W-1:0] sr_q,  sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (cap_en_i) begin
            sr_d  = cap_word_i;
            cnt_d = '0;
        end else if (shift_en_i) begin
            sr_d = {tdi_i, sr_q[DATA_W-1:1]};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr_o   = sr_q;
    assign full_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/cpu_debug_scan_engine.sv
// -----------------------------------------------------------------------------
// cpu_debug_scan_engine
// Virtual-JTAG style scan engine: an instruction register selects one of
// N_CH capture words, the word is shifted out on tdo while tdi is shifted in,
// and a fully shifted word is delivered on a valid/ready interface.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   tck_en                          : scan-step qualifier for all vs_* strobes
//   ir_in / vs_uir                  : instruction and its update strobe
//   vs_cdr, vs_sdr, vs_udr          : capture, shift and update strobes
//   tdi / tdo                       : serial data in / out (tdo = sr[0])
//   cap_data                        : N_CH capture words, channel k at k*DATA_W
//   ir_out                          : status {.., overrun, update pending}
//   jdo, upd_ch, upd_valid/upd_ready: delivered word, its channel, handshake
//   short_scan, overrun             : sticky error flags, cleared by vs_uir
// -----------------------------------------------------------------------------
module cpu_debug_scan_engine
    import cpu_debug_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IR_W   = DEF_IR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tck_en,
    input  logic [IR_W-1:0]            ir_in,
    input  logic                       vs_cdr,
    input  logic                       vs_sdr,
    input  logic                       vs_udr,
    input  logic                       vs_uir,
    input  logic                       tdi,
    output logic                       tdo,
    input  logic [(2**IR_W)*DATA_W-1:0] cap_data,
    output logic [IR_W-1:0]            ir_out,
    output logic [DATA_W-1:0]          jdo,
    output logic                       upd_valid,
    output logic [IR_W-1:0]            upd_ch,
    input  logic                       upd_ready,
    output logic                       short_scan,
    output logic                       overrun
);

    scan_act_e         act;
    scan_state_e       state_q, state_d;

    logic [IR_W-1:0]   ir_q,        ir_d;
    logic [DATA_W-1:0] jdo_q,       jdo_d;
    logic [IR_W-1:0]   upd_ch_q,    upd_ch_d;
    logic              upd_valid_q, upd_valid_d;
    logic              short_q,     short_d;
    logic              overrun_q,   overrun_d;

    logic [DATA_W-1:0] cap_word;
    logic [DATA_W-1:0] sr;
    logic              cnt_full;

    assign act      = decode_step(tck_en, vs_uir, vs_cdr, vs_sdr, vs_udr);
    assign cap_word = cap_data[int'(ir_q)*DATA_W +: DATA_W];

    cpu_debug_scan_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk        (clk),
        .reset      (reset),
        .cap_en_i   (act == ACT_CDR),
        .shift_en_i (act == ACT_SDR),
        .cap_word_i (cap_word),
        .tdi_i      (tdi),
        .sr_o       (sr),
        .full_o     (cnt_full)
    );

    // Scan FSM next state: track where in the capture/shift/update sequence
    // the host is.
    always_comb begin
        state_d = state_q;
        case (act)
            ACT_UIR, ACT_UDR: state_d = ST_IDLE;
            ACT_CDR:          state_d = ST_CAPTURED;
            ACT_SDR:          state_d = ST_SHIFTING;
            default:          state_d = state_q;
        endcase
    end

    // Instruction, delivery handshake and sticky flags.
    always_comb begin
        ir_d        = ir_q;
        jdo_d       = jdo_q;
        upd_ch_d    = upd_ch_q;
        short_d     = short_q;
        overrun_d   = overrun_q;
        // A consumed word retires unless an update below replaces it.
        upd_valid_d = upd_valid_q && !upd_ready;

        case (act)
            ACT_UIR: begin
                ir_d      = ir_in;
                short_d   = 1'b0;
                overrun_d = 1'b0;
            end
            ACT_UDR: begin
                if (!cnt_full) begin
                    short_d = 1'b1;
                end else if (upd_valid_q && !upd_ready) begin
                    // Old word still owned by the consumer: keep it intact.
                    overrun_d = 1'b1;
                end else begin
                    // Either nothing pending or the old word is being
                    // accepted this cycle, so the new one can take its slot.
                    jdo_d       = sr;
                    upd_ch_d    = ir_q;
                    upd_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            jdo_q       <= '0;
            upd_ch_q    <= '0;
            upd_valid_q <= 1'b0;
            short_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            jdo_q       <= jdo_d;
            upd_ch_q    <= upd_ch_d;
            upd_valid_q <= upd_valid_d;
            short_q     <= short_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        ir_out                  = '0;
        ir_out[IR_OUT_PEND_BIT] = upd_valid_q;
        ir_out[IR_OUT_OVR_BIT]  = overrun_q;
    end

    assign tdo        = sr[0];
    assign jdo        = jdo_q;
    assign upd_ch     = upd_ch_q;
    assign upd_valid  = upd_valid_q;
    assign short_scan = short_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_cpu_debug_scan_engine.sv
// -----------------------------------------------------------------------------
// tb_cpu_debug_scan_engine
// Directed scenarios followed by randomized strobes, all compared every cycle
// against a behavioural model (bit queue for the scan register, plain
// variables for the delivery slot and flags).
// -----------------------------------------------------------------------------
module tb_cpu_debug_scan_engine;

    localparam int DW  = 38;
    localparam int IW  = 2;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              tck_en;
    logic [IW-1:0]     ir_in;
    logic              vs_cdr, vs_sdr, vs_udr, vs_uir;
    logic              tdi;
    logic              tdo;
    logic [NCH*DW-1:0] cap_data;
    logic [IW-1:0]     ir_out;
    logic [DW-1:0]     jdo;
    logic              upd_valid;
    logic [IW-1:0]     upd_ch;
    logic              upd_ready;
    logic              short_scan;
    logic              overrun;

    cpu_debug_scan_engine #(.DATA_W(DW), .IR_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .tck_en     (tck_en),
        .ir_in      (ir_in),
        .vs_cdr     (vs_cdr),
        .vs_sdr     (vs_sdr),
        .vs_udr     (vs_udr),
        .vs_uir     (vs_uir),
        .tdi        (tdi),
        .tdo        (tdo),
        .cap_data   (cap_data),
        .ir_out     (ir_out),
        .jdo        (jdo),
        .upd_valid  (upd_valid),
        .upd_ch     (upd_ch),
        .upd_ready  (upd_ready),
        .short_scan (short_scan),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit            ref_sr[$];   // ref_sr[0] is the bit presented on tdo
    int            ref_cnt;
    logic [IW-1:0] ref_ir;
    bit            ref_valid;
    logic [DW-1:0] ref_jdo;
    logic [IW-1:0] ref_ch;
    bit            ref_short;
    bit            ref_over;

    function automatic logic [DW-1:0] ref_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW; i++) w[i] = ref_sr[i];
        return w;
    endfunction

    task automatic model_reset();
        ref_sr.delete();
        for (int i = 0; i < DW; i++) ref_sr.push_back(1'b0);
        ref_cnt   = 0;
        ref_ir    = '0;
        ref_valid = 1'b0;
        ref_jdo   = '0;
        ref_ch    = '0;
        ref_short = 1'b0;
        ref_over  = 1'b0;
    endtask

    // Applies the inputs seen at this rising edge to the model.
    task automatic model_edge();
        bit next_valid;
        if (reset) begin
            model_reset();
            return;
        end
        next_valid = ref_valid && !upd_ready;
        if (tck_en) begin
            if (vs_uir) begin
                ref_ir    = ir_in;
                ref_short = 1'b0;
                ref_over  = 1'b0;
            end else if (vs_cdr) begin
                ref_sr.delete();
                for (int i = 0; i < DW; i++) ref_sr.push_back(cap_data[int'(ref_ir)*DW + i]);
                ref_cnt = 0;
            end else if (vs_sdr) begin
                void'(ref_sr.pop_front());
                ref_sr.push_back(tdi);
                if (ref_cnt < DW) ref_cnt++;
            end else if (vs_udr) begin
                if (ref_cnt < DW) begin
                    ref_short = 1'b1;
                end else if (ref_valid && !upd_ready) begin
                    ref_over = 1'b1;
                end else begin
                    ref_jdo    = ref_word();
                    ref_ch     = ref_ir;
                    next_valid = 1'b1;
                end
            end
        end
        ref_valid = next_valid;
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, ".tdo"},        64'(tdo),        64'(ref_sr[0]));
        check({pfx, ".jdo"},        64'(jdo),        64'(ref_jdo));
        check({pfx, ".upd_valid"},  64'(upd_valid),  64'(ref_valid));
        check({pfx, ".upd_ch"},     64'(upd_ch),     64'(ref_ch));
        check({pfx, ".short_scan"}, 64'(short_scan), 64'(ref_short));
        check({pfx, ".overrun"},    64'(overrun),    64'(ref_over));
        check({pfx, ".ir_out"},     64'(ir_out),     64'({ref_over, ref_valid}));
    endtask

    task automatic tick(input string pfx);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(pfx);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_step(input bit u, input bit c, input bit s, input bit d,
                           input bit t, input bit rdy, input string pfx, input bit en = 1'b1);
        tck_en    = en;
        vs_uir    = u;
        vs_cdr    = c;
        vs_sdr    = s;
        vs_udr    = d;
        tdi       = t;
        upd_ready = rdy;
        tick(pfx);
        vs_uir = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0;
        upd_ready = 1'b0;
    endtask

    task automatic full_scan(input logic [DW-1:0] w, input bit rdy, input string pfx);
        do_step(0, 1, 0, 0, 0, 0, pfx);
        for (int i = 0; i < DW; i++) do_step(0, 0, 1, 0, w[i], 0, pfx);
        do_step(0, 0, 0, 1, 0, rdy, pfx);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW; i++) w[i] = 1'($urandom);
        return w;
    endfunction

    logic [DW-1:0] slice2;
    logic [DW-1:0] pat;
    logic [DW-1:0] w1, w2, w3;

    initial begin
        slice2 = 38'h2A_5555_AAAA;
        pat    = 38'h15_0F0F_F0F0;

        reset = 1'b1; tck_en = 1'b0; ir_in = '0; tdi = 1'b0; upd_ready = 1'b0;
        vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0;
        for (int k = 0; k < NCH*DW; k++) cap_data[k] = 1'($urandom);
        cap_data[2*DW +: DW] = slice2;
        model_reset();

        tick("reset");
        tick("reset");
        check("reset.ir_out_zero", 64'(ir_out), 64'd0);
        check("reset.tdo_zero",    64'(tdo),    64'd0);
        reset = 1'b0;

        // Capture channel 2 and shift it out LSB first while shifting pat in.
        ir_in = 2'd2;
        do_step(1, 0, 0, 0, 0, 0, "uir");
        do_step(0, 1, 0, 0, 0, 0, "cdr");
        for (int i = 0; i < DW; i++) begin
            check($sformatf("scan.tdo_bit%0d", i), 64'(tdo), 64'(slice2[i]));
            do_step(0, 0, 1, 0, pat[i], 0, "shift");
        end
        check("udr.valid_before", 64'(upd_valid), 64'd0);
        do_step(0, 0, 0, 1, 0, 0, "udr");
        check("udr.valid_latency1", 64'(upd_valid), 64'd1);
        check("udr.jdo_pattern",    64'(jdo),       64'(pat));
        check("udr.upd_ch",         64'(upd_ch),    64'd2);

        // Strobe ignored while tck_en is low.
        do_step(0, 0, 1, 0, 1, 0, "gated", 1'b0);
        check("gated.tdo_hold", 64'(tdo), 64'(pat[0]));

        // Consume, then a short scan is dropped.
        do_step(0, 0, 0, 0, 0, 1, "consume");
        check("consume.valid_low", 64'(upd_valid), 64'd0);
        do_step(0, 1, 0, 0, 0, 0, "short");
        for (int i = 0; i < 10; i++) do_step(0, 0, 1, 0, 1'($urandom), 0, "short");
        do_step(0, 0, 0, 1, 0, 0, "short");
        check("short.flag",   64'(short_scan), 64'd1);
        check("short.valid",  64'(upd_valid),  64'd0);
        check("short.ir_out", 64'(ir_out),     64'd0);
        do_step(1, 0, 0, 0, 0, 0, "uir_clear");
        check("uir_clear.short", 64'(short_scan), 64'd0);

        // Overrun: second full scan while the first word is still pending.
        w1 = rand_word();
        w2 = rand_word();
        full_scan(w1, 0, "ovr1");
        full_scan(w2, 0, "ovr2");
        check("ovr.flag",     64'(overrun), 64'd1);
        check("ovr.jdo_hold", 64'(jdo),     64'(w1));
        check("ovr.ir_out",   64'(ir_out),  64'd3);

        // Replace: ready coincides with a full-count update.
        ir_in = 2'd1;
        do_step(1, 0, 0, 0, 0, 0, "uir_ch1");
        w3 = rand_word();
        full_scan(w3, 1, "replace");
        check("replace.jdo",     64'(jdo),       64'(w3));
        check("replace.valid",   64'(upd_valid), 64'd1);
        check("replace.overrun", 64'(overrun),   64'd0);
        check("replace.upd_ch",  64'(upd_ch),    64'd1);

        // Reset in the middle of a scan with a word pending.
        do_step(0, 1, 0, 0, 0, 0, "midrst");
        for (int i = 0; i < 20; i++) do_step(0, 0, 1, 0, 1, 0, "midrst");
        reset = 1'b1;
        tick("midrst.reset");
        check("midrst.tdo_in_reset", 64'(tdo), 64'd0);
        reset = 1'b0;
        do_step(0, 0, 0, 1, 0, 0, "midrst.udr");
        check("midrst.valid", 64'(upd_valid),  64'd0);
        check("midrst.short", 64'(short_scan), 64'd1);
        for (int i = 0; i < 3; i++) do_step(0, 0, 0, 0, 0, 0, "midrst.idle");

        // Randomized strobes, including simultaneous ones and gated steps.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset     = ($urandom_range(0, 399) == 0);
            tck_en    = ($urandom_range(0, 9) != 0);
            vs_uir    = (r < 3)            || ($urandom_range(0, 31) == 0);
            vs_cdr    = (r >= 3 && r < 7)  || ($urandom_range(0, 15) == 0);
            vs_udr    = (r >= 7 && r < 14) || ($urandom_range(0, 15) == 0);
            vs_sdr    = (r >= 14)          || ($urandom_range(0, 15) == 0);
            ir_in     = IW'($urandom);
            tdi       = 1'($urandom);
            upd_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) begin
                for (int k = 0; k < NCH*DW; k++) cap_data[k] = 1'($urandom);
            end
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
